// File: rtl/rv32i_types.sv
// ============================================================================
// Module : rv32i_types
// Brief  : Shared CDB types, widths and the round-robin wrap helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32i_types;

  localparam int CDB_TAG_W  = 4;
  localparam int CDB_DATA_W = 32;

  // Broadcast bundle as seen by RS/ROB/rename snoop ports.
  typedef struct packed {
    logic                  vld;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_pkt_t;

  // (base + off) mod n for base < n and off <= n, with no power-of-two assumption.
  function automatic int unsigned rr_wrap(int unsigned base, int unsigned off, int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin pick over N requesters with a wrapping priority pointer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import rv32i_types::*;
#(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] r_ptr;
  logic [N-1:0]     w_gnt;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;
  logic [PTR_W-1:0] w_cand;

  // Grant depends only on req and the pointer; rst masks it so no transfer occurs.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int off = 0; off < N; off++) begin
      w_cand = PTR_W'(rr_wrap(32'(r_ptr), 32'(off), 32'(N)));
      if (!rst && !w_found && req[w_cand]) begin
        w_found        = 1'b1;
        w_gnt[w_cand]  = 1'b1;
        w_idx          = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= PTR_W'(rr_wrap(32'(w_idx), 32'd1, 32'(N)));
    end
  end

  assign gnt = w_gnt;
  assign idx = w_idx;
  assign any = w_found;

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module : cdb_arbiter
// Brief  : Grants one execution-unit result per cycle and registers it onto the CDB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
  import rv32i_types::*;
#(
  parameter  int N_EXU = 4,
  parameter  int TAG_W = 4,
  localparam int PTR_W = $clog2(N_EXU)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_EXU-1:0]            exu_req,
  input  logic [N_EXU*TAG_W-1:0]      exu_tag,
  input  logic [N_EXU*CDB_DATA_W-1:0] exu_wdata,
  output logic [N_EXU-1:0]            exu_rdy,
  output logic                        cdb_vld,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [CDB_DATA_W-1:0]       cdb_data,
  output logic [PTR_W-1:0]            cdb_src
);

  logic [N_EXU-1:0]      w_gnt;
  logic [PTR_W-1:0]      w_idx;
  logic                  w_any;
  logic [TAG_W-1:0]      w_tag;
  logic [CDB_DATA_W-1:0] w_data;

  logic                  r_vld;
  logic [TAG_W-1:0]      r_tag;
  logic [CDB_DATA_W-1:0] r_data;
  logic [PTR_W-1:0]      r_src;

  rr_arbiter #(.N(N_EXU)) u_rr (
    .clk (clk),
    .rst (rst),
    .req (exu_req),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  // One-hot AND-OR mux keeps tag/wdata entirely off the grant path.
  always_comb begin
    w_tag  = '0;
    w_data = '0;
    for (int i = 0; i < N_EXU; i++) begin
      if (w_gnt[i]) begin
        w_tag  = w_tag  | exu_tag[i*TAG_W +: TAG_W];
        w_data = w_data | exu_wdata[i*CDB_DATA_W +: CDB_DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_tag  <= '0;
      r_data <= '0;
      r_src  <= '0;
    end else begin
      r_vld  <= w_any;
      r_tag  <= w_tag;
      r_data <= w_data;
      if (w_any) begin
        r_src <= w_idx;
      end
    end
  end

  assign exu_rdy  = w_gnt;
  assign cdb_vld  = r_vld;
  assign cdb_tag  = r_tag;
  assign cdb_data = r_data;
  assign cdb_src  = r_src;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module : tb_cdb_arbiter
// Brief  : Directed self-checking bench for cdb_arbiter (N_EXU=4 and N_EXU=3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req4;
  logic [15:0]  tag4;
  logic [127:0] data4;
  logic [3:0]   rdy4;
  logic         vld4;
  logic [3:0]   ctag4;
  logic [31:0]  cdata4;
  logic [1:0]   src4;

  logic [2:0]   req3;
  logic [11:0]  tag3;
  logic [95:0]  data3;
  logic [2:0]   rdy3;
  logic         vld3;
  logic [3:0]   ctag3;
  logic [31:0]  cdata3;
  logic [1:0]   src3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_EXU(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst), .exu_req(req4), .exu_tag(tag4), .exu_wdata(data4),
    .exu_rdy(rdy4), .cdb_vld(vld4), .cdb_tag(ctag4), .cdb_data(cdata4), .cdb_src(src4)
  );

  cdb_arbiter #(.N_EXU(3), .TAG_W(4)) dut3 (
    .clk(clk), .rst(rst), .exu_req(req3), .exu_tag(tag3), .exu_wdata(data3),
    .exu_rdy(rdy3), .cdb_vld(vld3), .cdb_tag(ctag3), .cdb_data(cdata3), .cdb_src(src3)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    req4  = 4'b1111;
    tag4  = '0;
    data4 = '0;
    req3  = '0;
    tag3  = '0;
    data3 = '0;

    // Reset with every port requesting: no grant, cleared broadcast.
    #1;
    check("rst_rdy_comb", rdy4, 0);
    step();
    check("rst_rdy", rdy4, 0);
    check("rst_vld", vld4, 0);
    check("rst_tag", ctag4, 0);
    check("rst_data", cdata4, 0);
    check("rst_src", src4, 0);

    // Single request on port 2.
    rst  = 1'b0;
    req4 = 4'b0100;
    tag4[8 +: 4]   = 4'd5;
    data4[64 +: 32] = 32'hDEADBEEF;
    #1;
    check("single_rdy", rdy4, 4'b0100);
    step();
    req4 = 4'b0000;
    #1;
    check("single_rdy_after", rdy4, 0);
    check("single_vld", vld4, 1);
    check("single_tag", ctag4, 5);
    check("single_data", cdata4, 32'hDEADBEEF);
    check("single_src", src4, 2);
    step();
    check("single_vld_drop", vld4, 0);
    check("single_tag_clr", ctag4, 0);
    check("single_data_clr", cdata4, 0);
    check("single_src_hold", src4, 2);

    // All four requesting continuously from reset: grants 0,1,2,3,0,...
    rst  = 1'b1;
    req4 = 4'b1111;
    for (int p = 0; p < 4; p++) begin
      tag4[p*4 +: 4]   = 4'(p + 8);
      data4[p*32 +: 32] = 32'h1000 + 32'(p);
    end
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("rr_rdy", rdy4, 64'(4'b0001 << (i % 4)));
      step();
      check("rr_vld", vld4, 1);
      check("rr_tag", ctag4, 64'((i % 4) + 8));
      check("rr_data", cdata4, 64'(32'h1000 + 32'(i % 4)));
      check("rr_src", src4, 64'(i % 4));
    end

    // Back-to-back: port 0 sole requester with a fresh tag every cycle.
    rst  = 1'b1;
    req4 = 4'b0000;
    step();
    rst  = 1'b0;
    req4 = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tag4[3:0]   = 4'(i + 1);
      data4[31:0] = 32'(i * 3 + 7);
      #1;
      check("b2b_rdy", rdy4, 4'b0001);
      step();
      check("b2b_vld", vld4, 1);
      check("b2b_tag", ctag4, 64'(i + 1));
      check("b2b_data", cdata4, 64'(i * 3 + 7));
    end
    req4 = 4'b0000;
    step();
    check("b2b_end_vld", vld4, 0);

    // Mid-operation reset: broadcast pending and port 1 requesting.
    req4 = 4'b0001;
    tag4[3:0] = 4'd3;
    step();
    check("mid_pending_vld", vld4, 1);
    rst  = 1'b1;
    req4 = 4'b0010;
    tag4[7:4]    = 4'd7;
    data4[63:32] = 32'hCAFE0001;
    #1;
    check("mid_rst_rdy", rdy4, 0);
    step();
    check("mid_vld_clr", vld4, 0);
    check("mid_tag_clr", ctag4, 0);
    check("mid_src_clr", src4, 0);
    rst = 1'b0;
    #1;
    check("mid_post_rdy", rdy4, 4'b0010);
    step();
    check("mid_post_vld", vld4, 1);
    check("mid_post_tag", ctag4, 7);
    check("mid_post_data", cdata4, 32'hCAFE0001);
    check("mid_post_src", src4, 1);
    req4 = 4'b0000;

    // Wrap with N_EXU=3: move pointer to 2 by granting port 1.
    req3 = 3'b010;
    tag3[7:4] = 4'd1;
    #1;
    check("w3_p1_rdy", rdy3, 3'b010);
    step();
    req3 = 3'b101;
    tag3[3:0]  = 4'd4;
    tag3[11:8] = 4'd9;
    #1;
    check("w3_p2_rdy", rdy3, 3'b100);
    step();
    check("w3_p2_src", src3, 2);
    check("w3_p2_tag", ctag3, 9);
    check("w3_p0_rdy", rdy3, 3'b001);
    step();
    check("w3_p0_src", src3, 0);
    check("w3_p0_tag", ctag3, 4);
    check("w3_p2_again_rdy", rdy3, 3'b100);
    req3 = 3'b000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common data bus arbiter and broadcaster. It is the CDB-side responder for every execution unit's result port. Each cycle it grants at most one pending result using round-robin priority and registers the winner onto the CDB. Reservation stations, the ROB and the register-rename logic snoop the CDB. It sits between the functional units (ALU, multiplier, load/store) and all CDB consumers.

## Interface
Parameters:
- N_EXU, 4, number of execution-unit result ports (≥2, need not be a power of two)
- TAG_W, 4, ROB/physical tag width
- PTR_W, $clog2(N_EXU), round-robin pointer width (derived, not overridden)

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exu_req  in  N_EXU  per-port result valid; the unit holds it with tag/wdata stable until granted
- exu_tag  in  N_EXU×TAG_W  per-port result tag
- exu_wdata  in  N_EXU×32  per-port result data
- exu_rdy  out  N_EXU  per-port grant, combinational, one-hot or zero
- cdb_vld  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  32  broadcast data
- cdb_src  out  PTR_W  index of the port that produced the broadcast (debug/perf)

Port i is the cdb modport of exu2cdb_itf instance i: req, tag and wdata map to exu_req[i], exu_tag[i] and exu_wdata[i], and rdy maps to exu_rdy[i].

## Operation
- Transfer on port i occurs when exu_req[i] && exu_rdy[i]. The unit drops req or presents a new result the following cycle.
- Arbitration:
  - Scan ports in order rr_ptr, rr_ptr+1, …, wrapping modulo N_EXU.
  - The first port with exu_req set is granted; exu_rdy has only that bit set.
  - With no requests, exu_rdy = 0.
- Pointer update: on a grant to port k, rr_ptr ← (k+1) mod N_EXU, with explicit wrap (no reliance on power-of-two overflow). With no grant, rr_ptr holds.
- Broadcast register, updated every cycle:
  - cdb_vld ← any grant.
  - On a grant: cdb_tag ← exu_tag[k], cdb_data ← exu_wdata[k], cdb_src ← k.
  - With no grant: cdb_tag and cdb_data ← 0, cdb_src holds.
- The CDB never stalls. Consumers must accept every cdb_vld cycle.
- exu_rdy must not depend on any input other than exu_req and rr_ptr. No combinational path from tag or wdata to rdy.
- Reset values: rr_ptr=0, cdb_vld=0, cdb_tag=0, cdb_data=0, cdb_src=0. exu_rdy is 0 while rst is high, regardless of exu_req.
- Reset mid-operation:
  - A grant in the rst cycle is suppressed, so the unit keeps its result.
  - A broadcast already in the register is cleared. Upstream flush/recovery is responsible for any lost result.

## Timing
- Grant-to-broadcast latency is 1 cycle: the result accepted at edge t appears on the cdb_* outputs during cycle t+1.
- Throughput is 1 result per cycle aggregate.
- A single unit requesting continuously is granted every cycle. Combined with the FU's `rdy = ~full || rd_vld`, this gives back-to-back results.
- Fairness: with all N_EXU ports requesting continuously, each port is granted exactly once in every N_EXU consecutive cycles. Worst-case wait is N_EXU-1 cycles.
- Simultaneous events:
  - A port that was just granted and re-requests in the next cycle has lowest priority in that cycle.
  - A new request arriving in the same cycle as a grant to another port is not granted that cycle.

## Structure
- Shared package (rv32i_types):
  - cdb_pkt_t struct {vld, tag[TAG_W], data[32]} for the broadcast bundle, reused by RS/ROB snoop ports.
  - CDB_TAG_W constant.
- One natural sub-module: rr_arbiter (parameter N), containing the combinational round-robin pick with the pointer register and its wrap logic. It has inputs req[N] and rst, and outputs a one-hot gnt[N] plus the encoded index. cdb_arbiter instantiates it and adds the mux and broadcast register.

## Test plan
- Reset: hold rst with exu_req=4'b1111 → exu_rdy=0, cdb_vld=0, cdb_tag=0, cdb_data=0 after the reset cycle; rr_ptr=0.
- Single port: port 2 requests tag=5, data=0xDEADBEEF for 1 cycle → exu_rdy=4'b0100 that cycle; next cycle cdb_vld=1, cdb_tag=5, cdb_data=0xDEADBEEF, cdb_src=2; the cycle after, cdb_vld=0.
- Round-robin: all 4 ports request continuously from reset → grants 0,1,2,3,0,… one per cycle; broadcasts follow with 1-cycle lag, in the same order.
- Wrap with N_EXU=3: rr_ptr=2, ports 0 and 2 requesting → grant 2, pointer wraps to 0; next cycle grant 0.
- Back-to-back: the ALU presents a result every cycle on port 0 and is the sole requester → exu_rdy[0]=1 every cycle, cdb_vld=1 every cycle from cycle 2 on, and the tag sequence is preserved.
- Mid-operation reset: rst asserted while port 1 is requesting and a broadcast is pending → no grant, and cdb_vld=0 next cycle. After rst drops, port 1 is granted first (rr_ptr=0, port 0 idle).
